// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C bus front end.
// Holds filter/timeout defaults, the event bundle and bus state.
package i2c_pkg;

    localparam int I2C_FILTER_LEN_DEFAULT = 4;
    localparam int I2C_TIMEOUT_DEFAULT    = 25000;
    localparam int I2C_TIMEOUT_W          = 16;
    localparam int I2C_FILTER_CNT_W       = 4;

    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } i2c_bus_evt_t;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: 2-flop synchronizer followed by a persistence filter.
// Ports: clk, n_rst (async, active low), i_line raw pad, o_level filtered.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int   FILTER_LEN = I2C_FILTER_LEN_DEFAULT,
    parameter logic RST_VAL    = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_line,
    output logic o_level
);

    localparam logic [I2C_FILTER_CNT_W-1:0] CNT_LAST =
        I2C_FILTER_CNT_W'(FILTER_LEN - 1);
    localparam logic [I2C_FILTER_CNT_W-1:0] CNT_ONE =
        I2C_FILTER_CNT_W'(1);

    logic                        r_s1;
    logic                        r_s2;
    logic                        r_f;
    logic [I2C_FILTER_CNT_W-1:0] r_cnt;

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_len_chk
        $error("i2c_line_filter: FILTER_LEN out of range 1..15");
    end

    // The counter tracks how long s2 has disagreed with the filtered
    // level; any agreement restarts the run, so short glitches vanish.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s1  <= RST_VAL;
            r_s2  <= RST_VAL;
            r_f   <= RST_VAL;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_line;
            r_s2 <= r_s1;
            if (r_s2 == r_f) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_f   <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_level = r_f;

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C front end: filtered SDA/SCL, edge and START/STOP pulses, busy state.
// Ports: clk, n_rst (async, active low), SDA_in/SCL_in raw pads,
//   SDA_sync/SCL_sync filtered levels, SCL_rise/SCL_fall,
//   start_detected/stop_detected one-cycle pulses, bus_busy level,
//   bus_timeout pulse (stuck SCL).
// Build option: define I2C_BUS_TIMEOUT_EN to include the stuck-SCL
//   timeout; without it bus_timeout is 0 and only STOP frees the bus.
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN     = I2C_FILTER_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic SDA_in,
    input  logic SCL_in,
    output logic SDA_sync,
    output logic SCL_sync,
    output logic SCL_rise,
    output logic SCL_fall,
    output logic start_detected,
    output logic stop_detected,
    output logic bus_busy,
    output logic bus_timeout
);

    logic         w_sda_f;
    logic         w_scl_f;
    logic         r_sda_fp;
    logic         r_scl_fp;
    i2c_bus_evt_t w_evt;
    i2c_bus_evt_t r_evt;
    bus_state_t   r_state;
    bus_state_t   w_state_nxt;
    logic         w_to_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_to_chk
        $error("i2c_bus_conditioner: TIMEOUT_CYCLES out of range");
    end

    i2c_line_filter #(
        .FILTER_LEN (FILTER_LEN),
        .RST_VAL    (1'b1)
    ) u_sda_filt (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_line  (SDA_in),
        .o_level (w_sda_f)
    );

    i2c_line_filter #(
        .FILTER_LEN (FILTER_LEN),
        .RST_VAL    (1'b1)
    ) u_scl_filt (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_line  (SCL_in),
        .o_level (w_scl_f)
    );

    // START/STOP require SCL high on both sides of the SDA change, so an
    // SDA change coinciding with an SCL edge only yields the edge pulse.
    always_comb begin
        w_evt          = '0;
        w_evt.scl_rise = !r_scl_fp && w_scl_f;
        w_evt.scl_fall = r_scl_fp && !w_scl_f;
        w_evt.start    = r_scl_fp && w_scl_f && r_sda_fp && !w_sda_f;
        w_evt.stop     = r_scl_fp && w_scl_f && !r_sda_fp && w_sda_f;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sda_fp <= 1'b1;
            r_scl_fp <= 1'b1;
            r_evt    <= '0;
        end else begin
            r_sda_fp <= w_sda_f;
            r_scl_fp <= w_scl_f;
            r_evt    <= w_evt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A START while busy is a repeated START and keeps the bus owned;
    // a STOP while idle is reported but changes nothing.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BUS_IDLE: begin
                if (w_evt.start) begin
                    w_state_nxt = BUS_BUSY;
                end
            end
            BUS_BUSY: begin
                if (w_evt.stop || w_to_hit) begin
                    w_state_nxt = BUS_IDLE;
                end
            end
            default: begin
                w_state_nxt = BUS_IDLE;
            end
        endcase
    end

`ifdef I2C_BUS_TIMEOUT_EN
    localparam logic [I2C_TIMEOUT_W-1:0] TO_LAST =
        I2C_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [I2C_TIMEOUT_W-1:0] TO_ONE =
        I2C_TIMEOUT_W'(1);

    logic [I2C_TIMEOUT_W-1:0] r_to_cnt;
    logic                     r_timeout;
    logic                     w_to_run;

    assign w_to_run = (r_state == BUS_BUSY) && !w_scl_f;
    assign w_to_hit = w_to_run && (r_to_cnt == TO_LAST);

    // Counts clock cycles of SCL held low while the bus is owned.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (!w_to_run || w_to_hit) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_ONE;
            end
        end
    end

    assign bus_timeout = r_timeout;
`else
    assign w_to_hit    = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    assign SDA_sync       = w_sda_f;
    assign SCL_sync       = w_scl_f;
    assign SCL_rise       = r_evt.scl_rise;
    assign SCL_fall       = r_evt.scl_fall;
    assign start_detected = r_evt.start;
    assign stop_detected  = r_evt.stop;
    assign bus_busy       = (r_state == BUS_BUSY);

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Self-checking bench for i2c_bus_conditioner (FILTER_LEN=4, timeout 100).
// Directed scenarios plus random pad traffic against a window-based model.
module tb_i2c_bus_conditioner;

    localparam int FLEN = 4;
    localparam int TMO  = 100;
`ifdef I2C_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic n_rst;
    logic SDA_in;
    logic SCL_in;
    logic SDA_sync;
    logic SCL_sync;
    logic SCL_rise;
    logic SCL_fall;
    logic start_detected;
    logic stop_detected;
    logic bus_busy;
    logic bus_timeout;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bit m_sda_f, m_scl_f, m_sda_p, m_scl_p, m_busy;
    bit e_rise, e_fall, e_start, e_stop, e_to;
    int m_run;
    bit sda_h[$];
    bit scl_h[$];

    i2c_bus_conditioner #(
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .SDA_in         (SDA_in),
        .SCL_in         (SCL_in),
        .SDA_sync       (SDA_sync),
        .SCL_sync       (SCL_sync),
        .SCL_rise       (SCL_rise),
        .SCL_fall       (SCL_fall),
        .start_detected (start_detected),
        .stop_detected  (stop_detected),
        .bus_busy       (bus_busy),
        .bus_timeout    (bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_vec();
        return {SDA_sync, SCL_sync, SCL_rise, SCL_fall,
                start_detected, stop_detected, bus_busy, bus_timeout};
    endfunction

    function automatic logic [7:0] exp_vec();
        return {m_sda_f, m_scl_f, e_rise, e_fall,
                e_start, e_stop, m_busy, e_to};
    endfunction

    // True when the FLEN pad samples that have reached the filter input
    // (the newest two are still inside the synchronizer) all equal v.
    function automatic bit win_all(input bit q[$], input bit v);
        for (int i = 0; i < FLEN; i++) begin
            if (q[q.size() - 3 - i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_sda_f = 1; m_scl_f = 1; m_sda_p = 1; m_scl_p = 1;
        m_busy = 0; m_run = 0;
        e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0; e_to = 0;
        sda_h.delete();
        scl_h.delete();
        for (int i = 0; i < FLEN + 2; i++) begin
            sda_h.push_back(1'b1);
            scl_h.push_back(1'b1);
        end
    endtask

    task automatic model_step(input bit sda, input bit scl);
        e_rise  = !m_scl_p && m_scl_f;
        e_fall  = m_scl_p && !m_scl_f;
        e_start = m_scl_p && m_scl_f && m_sda_p && !m_sda_f;
        e_stop  = m_scl_p && m_scl_f && !m_sda_p && m_sda_f;
        e_to    = 0;
        if (TO_EN && m_busy && !m_scl_f) begin
            m_run++;
            if (m_run == TMO) begin
                e_to  = 1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (e_start) m_busy = 1;
        else if (e_stop || e_to) m_busy = 0;
        m_sda_p = m_sda_f;
        m_scl_p = m_scl_f;
        sda_h.push_back(sda);
        scl_h.push_back(scl);
        if (sda_h.size() > 32) begin
            void'(sda_h.pop_front());
            void'(scl_h.pop_front());
        end
        if (win_all(sda_h, !m_sda_f)) m_sda_f = !m_sda_f;
        if (win_all(scl_h, !m_scl_f)) m_scl_f = !m_scl_f;
    endtask

    task automatic tick(input bit sda, input bit scl);
        SDA_in = sda;
        SCL_in = scl;
        @(posedge clk);
        cyc++;
        if (n_rst) model_step(sda, scl);
        #1;
    endtask

    task automatic test_reset();
        int fall_at;
        n_rst = 0; SDA_in = 0; SCL_in = 1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_vec++;
        if (dut_vec() !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL reset_hold got=%b exp=%b", dut_vec(), 8'b1100_0000);
        end
        n_rst = 1;
        fall_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(0, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_rel t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            if (fall_at < 0 && SDA_sync === 1'b0) fall_at = i;
        end
        n_vec++;
        if (fall_at != 6) begin
            n_err++;
            $display("FAIL reset_latency got=%0d exp=6", fall_at);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_idle t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_glitch();
        int falls, lows;
        falls = 0; lows = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1, (i >= 2 && i < 5) ? 1'b0 : 1'b1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL glitch3 t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            falls += int'(SCL_fall);
            lows  += int'(!SCL_sync);
        end
        n_vec++;
        if (falls != 0 || lows != 0) begin
            n_err++;
            $display("FAIL glitch3_reject falls=%0d lows=%0d exp=0/0",
                     falls, lows);
        end
        falls = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1, (i >= 2 && i < 6) ? 1'b0 : 1'b1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL glitch4 t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            falls += int'(SCL_fall);
        end
        n_vec++;
        if (falls != 1) begin
            n_err++;
            $display("FAIL glitch4_pass falls=%0d exp=1", falls);
        end
    endtask

    task automatic test_start_stop();
        int starts, stops;
        starts = 0; stops = 0;
        for (int i = 0; i < 12; i++) begin
            tick(0, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL start t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            starts += int'(start_detected);
        end
        n_vec++;
        if (starts != 1 || bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy starts=%0d busy=%b exp=1/1",
                     starts, bus_busy);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stop t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            stops += int'(stop_detected);
        end
        n_vec++;
        if (stops != 1 || bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL stop_idle stops=%0d busy=%b exp=1/0",
                     stops, bus_busy);
        end
    endtask

    task automatic test_repeated_start();
        int starts, drops;
        bit sda_seq[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit scl_seq[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        starts = 0; drops = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rstart_a t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) begin
                tick(sda_seq[p], scl_seq[p]);
                n_vec++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL rstart_b t=%0d got=%b exp=%b",
                             cyc, dut_vec(), exp_vec());
                end
                starts += int'(start_detected);
                drops  += int'(!bus_busy);
            end
        end
        n_vec++;
        if (starts != 1 || drops != 0) begin
            n_err++;
            $display("FAIL rstart starts=%0d drops=%0d exp=1/0",
                     starts, drops);
        end
    endtask

    task automatic test_simultaneous();
        int rises, falls, ss;
        rises = 0; falls = 0; ss = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 10) tick(1, 0);
            else        tick(0, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL simul t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            rises += int'(SCL_rise);
            falls += int'(SCL_fall);
            ss    += int'(start_detected) + int'(stop_detected);
        end
        n_vec++;
        if (rises != 1 || falls != 1 || ss != 0 || bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL simul_evt r=%0d f=%0d ss=%0d busy=%b exp=1/1/0/1",
                     rises, falls, ss, bus_busy);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL simul_stop t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        int fall_at, to_at, to_cnt, exp_at, exp_cnt;
        bit exp_busy;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL to_start t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
        fall_at = -1; to_at = -1; to_cnt = 0;
        for (int i = 0; i < 130; i++) begin
            tick(0, 0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL to_hold t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            if (fall_at < 0 && SCL_sync === 1'b0) fall_at = i;
            if (bus_timeout === 1'b1) begin
                to_cnt++;
                if (to_at < 0) to_at = i;
            end
        end
        exp_at   = TO_EN ? fall_at + TMO : -1;
        exp_cnt  = TO_EN ? 1 : 0;
        exp_busy = !TO_EN;
        n_vec++;
        if (to_at != exp_at) begin
            n_err++;
            $display("FAIL to_latency got=%0d exp=%0d", to_at, exp_at);
        end
        n_vec++;
        if (to_cnt != exp_cnt) begin
            n_err++;
            $display("FAIL to_pulses got=%0d exp=%0d", to_cnt, exp_cnt);
        end
        n_vec++;
        if (bus_busy !== exp_busy) begin
            n_err++;
            $display("FAIL to_busy got=%b exp=%b", bus_busy, exp_busy);
        end
        for (int i = 0; i < 20; i++) begin
            tick((i < 10) ? 1'b0 : 1'b1, 1'b1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL to_clean t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clocked_traffic();
        int rises, falls, ss, drops;
        bit b;
        rises = 0; falls = 0; ss = 0; drops = 0;
        for (int i = 0; i < 25; i++) begin
            tick(0, (i < 10) ? 1'b1 : 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL traf_pre t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 10; k++) begin
            b = (k < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (k == 9 && i >= 15) break;
                tick(b, (i < 15) ? 1'b0 : 1'b1);
                n_vec++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL traf_bit t=%0d got=%b exp=%b",
                             cyc, dut_vec(), exp_vec());
                end
                rises += int'(SCL_rise);
                falls += int'(SCL_fall);
                ss    += int'(start_detected) + int'(stop_detected);
                drops += int'(!bus_busy);
            end
        end
        n_vec++;
        if (rises != 9 || falls != 9 || ss != 0 || drops != 0) begin
            n_err++;
            $display("FAIL traffic r=%0d f=%0d ss=%0d drops=%0d exp=9/9/0/0",
                     rises, falls, ss, drops);
        end
        for (int i = 0; i < 30; i++) begin
            tick((i < 15) ? 1'b0 : 1'b1, 1'b1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL traf_stop t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int rises_busy;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL mid_start t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
        end
        n_rst = 0;
        #2;
        n_vec++;
        if (dut_vec() !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL mid_async got=%b exp=%b", dut_vec(), 8'b1100_0000);
        end
        SDA_in = 1; SCL_in = 1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_rst = 1;
        rises_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL mid_idle t=%0d got=%b exp=%b",
                         cyc, dut_vec(), exp_vec());
            end
            rises_busy += int'(bus_busy);
        end
        n_vec++;
        if (rises_busy != 0) begin
            n_err++;
            $display("FAIL mid_forgot busy_cycles=%0d exp=0", rises_busy);
        end
        for (int i = 0; i < 10; i++) tick(0, 1);
        n_vec++;
        if (bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_restart busy=%b exp=1", bus_busy);
        end
        for (int i = 0; i < 10; i++) tick(1, 1);
    endtask

    task automatic test_random();
        bit s, c;
        int hold;
        s = 1; c = 1;
        for (int k = 0; k < 400; k++) begin
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 24) == 0) ? 110 : $urandom_range(1, 9);
            for (int j = 0; j < hold; j++) begin
                tick(s, c);
                n_vec++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL random t=%0d got=%b exp=%b",
                             cyc, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        n_rst = 0; SDA_in = 1; SCL_in = 1;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_glitch();
        test_start_stop();
        test_repeated_start();
        test_simultaneous();
        test_timeout();
        test_clocked_traffic();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
